// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared encodings and limits for the calculator key sequencer
package calc_pkg;

  typedef enum logic [2:0] {
    ST_ENTRY_A = 3'd0,
    ST_ENTRY_B = 3'd1,
    ST_EVAL    = 3'd2,
    ST_RESULT  = 3'd3,
    ST_ERROR   = 3'd4
  } state_t;

  localparam logic [1:0] OP_SUM = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [3:0] DIGIT_MAX   = 4'd9;
  localparam logic [3:0] KEY_OP_BASE = 4'd10;
  localparam logic [3:0] KEY_EQ      = 4'd14;
  localparam logic [3:0] KEY_CLR     = 4'd15;

  localparam logic [19:0] OPERAND_MAX = 20'd65535;

  function automatic logic [1:0] key_to_op(input logic [3:0] code);
    logic [3:0] rel;
    rel = code - KEY_OP_BASE;
    return rel[1:0];
  endfunction

endpackage

// File: rtl/calc_key_sequencer_if.sv
// rtl/calc_key_sequencer_if.sv - key input, ALU operand/result and display bundle
interface calc_key_sequencer_if;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] res;
  logic        isValid;
  logic [15:0] num1;
  logic [15:0] num2;
  logic [1:0]  op;
  logic        calc_go;
  logic [15:0] display;
  logic        busy;
  logic        error;

  modport master (
    input  key_valid, key_code, res, isValid,
    output num1, num2, op, calc_go, display, busy, error
  );

  modport slave (
    output key_valid, key_code, res, isValid,
    input  num1, num2, op, calc_go, display, busy, error
  );
endinterface

// File: rtl/calc_digit_accum.sv
// rtl/calc_digit_accum.sv - operand*10+digit with 16-bit overflow detection
module calc_digit_accum
  import calc_pkg::*;
(
  input  logic [15:0] operand,
  input  logic [3:0]  digit,
  output logic [15:0] sum,
  output logic        overflow
);

  // 20 bits holds the worst case 65535*10+9
  logic [19:0] full;

  always_comb begin
    full     = {4'b0000, operand} * 20'd10 + {16'h0000, digit};
    sum      = full[15:0];
    overflow = (full > OPERAND_MAX);
  end

endmodule

// File: rtl/calc_key_sequencer.sv
// rtl/calc_key_sequencer.sv - keypad-driven operand entry and ALU evaluation sequencer
module calc_key_sequencer
  import calc_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  calc_key_sequencer_if.master   bus
);

  state_t      state_q, state_d;
  logic [15:0] num1_q, num1_d;
  logic [15:0] num2_q, num2_d;
  logic [1:0]  op_q, op_d;
  logic        calc_go_q, calc_go_d;
  logic [15:0] display_q, display_d;
  logic        busy_q, busy_d;
  logic        error_q, error_d;
  logic        b_digit_q, b_digit_d;

  logic [15:0] acc_in, acc_sum;
  logic        acc_ovf;
  logic        is_digit, is_op, is_eq, is_clr;

  assign acc_in = (state_q == ST_ENTRY_B) ? num2_q : num1_q;

  calc_digit_accum u_accum (
    .operand  (acc_in),
    .digit    (bus.key_code),
    .sum      (acc_sum),
    .overflow (acc_ovf)
  );

  always_comb begin
    is_digit = bus.key_valid && (bus.key_code <= DIGIT_MAX);
    is_op    = bus.key_valid && (bus.key_code >= KEY_OP_BASE) && (bus.key_code < KEY_EQ);
    is_eq    = bus.key_valid && (bus.key_code == KEY_EQ);
    is_clr   = bus.key_valid && (bus.key_code == KEY_CLR);
  end

  always_comb begin
    state_d   = state_q;
    num1_d    = num1_q;
    num2_d    = num2_q;
    op_d      = op_q;
    display_d = display_q;
    b_digit_d = b_digit_q;
    calc_go_d = 1'b0;
    busy_d    = 1'b0;
    error_d   = error_q;

    if (is_clr) begin
      state_d   = ST_ENTRY_A;
      num1_d    = '0;
      num2_d    = '0;
      op_d      = OP_SUM;
      display_d = '0;
      b_digit_d = 1'b0;
      error_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_ENTRY_A: begin
          if (is_digit && !acc_ovf) begin
            num1_d    = acc_sum;
            display_d = acc_sum;
          end else if (is_op) begin
            op_d      = key_to_op(bus.key_code);
            num2_d    = '0;
            b_digit_d = 1'b0;
            state_d   = ST_ENTRY_B;
          end
        end
        ST_ENTRY_B: begin
          if (is_digit && !acc_ovf) begin
            num2_d    = acc_sum;
            display_d = acc_sum;
            b_digit_d = 1'b1;
          end else if (is_op && !b_digit_q) begin
            op_d = key_to_op(bus.key_code);
          end else if (is_eq) begin
            state_d   = ST_EVAL;
            calc_go_d = 1'b1;
            busy_d    = 1'b1;
          end
        end
        ST_EVAL: begin
          // The ALU result is captured on the edge that closes the single EVAL cycle
          if (bus.isValid) begin
            num1_d    = bus.res;
            display_d = bus.res;
            state_d   = ST_RESULT;
          end else begin
            display_d = '0;
            error_d   = 1'b1;
            state_d   = ST_ERROR;
          end
        end
        ST_RESULT: begin
          if (is_digit) begin
            num1_d    = {12'h000, bus.key_code};
            display_d = {12'h000, bus.key_code};
            state_d   = ST_ENTRY_A;
          end else if (is_op) begin
            op_d      = key_to_op(bus.key_code);
            num2_d    = '0;
            b_digit_d = 1'b0;
            state_d   = ST_ENTRY_B;
          end else if (is_eq) begin
            state_d   = ST_EVAL;
            calc_go_d = 1'b1;
            busy_d    = 1'b1;
          end
        end
        ST_ERROR: begin
          state_d = ST_ERROR;
        end
        default: begin
          state_d = ST_ENTRY_A;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_ENTRY_A;
      num1_q    <= '0;
      num2_q    <= '0;
      op_q      <= OP_SUM;
      calc_go_q <= 1'b0;
      display_q <= '0;
      busy_q    <= 1'b0;
      error_q   <= 1'b0;
      b_digit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      num1_q    <= num1_d;
      num2_q    <= num2_d;
      op_q      <= op_d;
      calc_go_q <= calc_go_d;
      display_q <= display_d;
      busy_q    <= busy_d;
      error_q   <= error_d;
      b_digit_q <= b_digit_d;
    end
  end

  assign bus.num1    = num1_q;
  assign bus.num2    = num2_q;
  assign bus.op      = op_q;
  assign bus.calc_go = calc_go_q;
  assign bus.display = display_q;
  assign bus.busy    = busy_q;
  assign bus.error   = error_q;

endmodule

// File: tb/tb_calc_key_sequencer.sv
// tb/tb_calc_key_sequencer.sv - directed vector table, reset corner cases and randomized model check
module tb_calc_key_sequencer;

  typedef struct {
    logic        kv;
    logic [3:0]  kc;
    logic [15:0] r;
    logic        iv;
    logic [52:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  calc_key_sequencer_if bus();

  calc_key_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_bad = 0;
  vec_t vt[$];

  // behavioural model state
  string m_mode;
  int    m_a, m_b, m_op, m_disp;
  bit    m_go, m_busy, m_err, m_bdig;

  function automatic logic [52:0] outs();
    return {bus.num1, bus.num2, bus.op, bus.calc_go, bus.display, bus.busy, bus.error};
  endfunction

  function automatic logic [52:0] pack(int n1, int n2, int o, bit g, int d, bit b, bit e);
    logic [15:0] a16, b16, d16;
    logic [1:0]  o2;
    a16 = 16'(n1); b16 = 16'(n2); d16 = 16'(d); o2 = 2'(o);
    return {a16, b16, o2, g, d16, b, e};
  endfunction

  function automatic vec_t mk(bit kv, int kc, int r, bit iv,
                              int n1, int n2, int o, bit g, int d, bit b, bit e);
    vec_t v;
    v.kv = kv; v.kc = 4'(kc); v.r = 16'(r); v.iv = iv;
    v.exp = pack(n1, n2, o, g, d, b, e);
    return v;
  endfunction

  task automatic check(string name, logic [52:0] got, logic [52:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = "A"; m_a = 0; m_b = 0; m_op = 0; m_disp = 0;
    m_go = 0; m_busy = 0; m_err = 0; m_bdig = 0;
  endtask

  task automatic model_step(bit kv, int kc, int r, bit iv);
    m_go = 0;
    m_busy = 0;
    if (kv && kc == 15) begin
      model_reset();
    end else if (m_mode == "EVAL") begin
      if (iv) begin m_a = r; m_disp = r; m_mode = "RES"; end
      else    begin m_disp = 0; m_mode = "ERR"; end
    end else if (kv && m_mode != "ERR") begin
      if (kc <= 9) begin
        if (m_mode == "RES") begin
          m_a = kc; m_disp = kc; m_mode = "A";
        end else if (m_mode == "A" && m_a * 10 + kc <= 65535) begin
          m_a = m_a * 10 + kc; m_disp = m_a;
        end else if (m_mode == "B" && m_b * 10 + kc <= 65535) begin
          m_b = m_b * 10 + kc; m_disp = m_b; m_bdig = 1;
        end
      end else if (kc <= 13) begin
        if (m_mode == "A" || m_mode == "RES") begin
          m_op = kc - 10; m_b = 0; m_bdig = 0; m_mode = "B";
        end else if (!m_bdig) begin
          m_op = kc - 10;
        end
      end else if (m_mode == "B" || m_mode == "RES") begin
        m_mode = "EVAL"; m_go = 1; m_busy = 1;
      end
    end
    m_err = (m_mode == "ERR");
  endtask

  task automatic press(int kc);
    bus.key_valid = 1'b1;
    bus.key_code  = 4'(kc);
    @(posedge clk);
    @(negedge clk);
    bus.key_valid = 1'b0;
  endtask

  initial begin
    bit prev_go;
    rst = 1'b1;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'd0;
    bus.res       = 16'd0;
    bus.isValid   = 1'b0;
    #1;
    check("reset_immediate", outs(), pack(0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    check("reset_held", outs(), pack(0, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;

    //          kv kc  res   iv  num1   num2 op go disp  busy err
    vt.push_back(mk(1, 5,  0,   0,  5,     0,  0, 0, 5,     0, 0));
    vt.push_back(mk(1, 10, 0,   0,  5,     0,  0, 0, 5,     0, 0));
    vt.push_back(mk(1, 1,  0,   0,  5,     1,  0, 0, 1,     0, 0));
    vt.push_back(mk(1, 14, 0,   0,  5,     1,  0, 1, 1,     1, 0));
    vt.push_back(mk(0, 0,  6,   1,  6,     1,  0, 0, 6,     0, 0));
    vt.push_back(mk(1, 11, 0,   0,  6,     0,  1, 0, 6,     0, 0));
    vt.push_back(mk(1, 2,  0,   0,  6,     2,  1, 0, 2,     0, 0));
    vt.push_back(mk(1, 14, 0,   0,  6,     2,  1, 1, 2,     1, 0));
    vt.push_back(mk(0, 0,  4,   1,  4,     2,  1, 0, 4,     0, 0));
    vt.push_back(mk(1, 14, 0,   0,  4,     2,  1, 1, 4,     1, 0));
    vt.push_back(mk(0, 0,  2,   1,  2,     2,  1, 0, 2,     0, 0));
    vt.push_back(mk(0, 0,  0,   0,  2,     2,  1, 0, 2,     0, 0));
    vt.push_back(mk(1, 15, 0,   0,  0,     0,  0, 0, 0,     0, 0));
    vt.push_back(mk(1, 6,  0,   0,  6,     0,  0, 0, 6,     0, 0));
    vt.push_back(mk(1, 5,  0,   0,  65,    0,  0, 0, 65,    0, 0));
    vt.push_back(mk(1, 5,  0,   0,  655,   0,  0, 0, 655,   0, 0));
    vt.push_back(mk(1, 3,  0,   0,  6553,  0,  0, 0, 6553,  0, 0));
    vt.push_back(mk(1, 5,  0,   0,  65535, 0,  0, 0, 65535, 0, 0));
    vt.push_back(mk(1, 0,  0,   0,  65535, 0,  0, 0, 65535, 0, 0));
    vt.push_back(mk(1, 15, 0,   0,  0,     0,  0, 0, 0,     0, 0));
    vt.push_back(mk(1, 8,  0,   0,  8,     0,  0, 0, 8,     0, 0));
    vt.push_back(mk(1, 13, 0,   0,  8,     0,  3, 0, 8,     0, 0));
    vt.push_back(mk(1, 0,  0,   0,  8,     0,  3, 0, 0,     0, 0));
    vt.push_back(mk(1, 14, 0,   0,  8,     0,  3, 1, 0,     1, 0));
    vt.push_back(mk(0, 0,  123, 0,  8,     0,  3, 0, 0,     0, 1));
    vt.push_back(mk(1, 1,  0,   0,  8,     0,  3, 0, 0,     0, 1));
    vt.push_back(mk(1, 15, 0,   0,  0,     0,  0, 0, 0,     0, 0));
    vt.push_back(mk(1, 3,  0,   0,  3,     0,  0, 0, 3,     0, 0));
    vt.push_back(mk(1, 10, 0,   0,  3,     0,  0, 0, 3,     0, 0));
    vt.push_back(mk(1, 12, 0,   0,  3,     0,  2, 0, 3,     0, 0));
    vt.push_back(mk(1, 4,  0,   0,  3,     4,  2, 0, 4,     0, 0));
    vt.push_back(mk(1, 14, 0,   0,  3,     4,  2, 1, 4,     1, 0));
    vt.push_back(mk(0, 0,  12,  1,  12,    4,  2, 0, 12,    0, 0));
    vt.push_back(mk(1, 15, 0,   0,  0,     0,  0, 0, 0,     0, 0));
    vt.push_back(mk(1, 3,  0,   0,  3,     0,  0, 0, 3,     0, 0));
    vt.push_back(mk(1, 10, 0,   0,  3,     0,  0, 0, 3,     0, 0));
    vt.push_back(mk(1, 4,  0,   0,  3,     4,  0, 0, 4,     0, 0));
    vt.push_back(mk(1, 12, 0,   0,  3,     4,  0, 0, 4,     0, 0));
    vt.push_back(mk(1, 15, 0,   0,  0,     0,  0, 0, 0,     0, 0));
    vt.push_back(mk(1, 7,  0,   0,  7,     0,  0, 0, 7,     0, 0));
    vt.push_back(mk(1, 14, 0,   0,  7,     0,  0, 0, 7,     0, 0));
    vt.push_back(mk(1, 15, 0,   0,  0,     0,  0, 0, 0,     0, 0));
    vt.push_back(mk(1, 1,  0,   0,  1,     0,  0, 0, 1,     0, 0));
    vt.push_back(mk(1, 10, 0,   0,  1,     0,  0, 0, 1,     0, 0));
    vt.push_back(mk(1, 2,  0,   0,  1,     2,  0, 0, 2,     0, 0));
    vt.push_back(mk(1, 14, 0,   0,  1,     2,  0, 1, 2,     1, 0));
    vt.push_back(mk(1, 15, 99,  1,  0,     0,  0, 0, 0,     0, 0));

    for (int i = 0; i < vt.size(); i++) begin
      bus.key_valid = vt[i].kv;
      bus.key_code  = vt[i].kc;
      bus.res       = vt[i].r;
      bus.isValid   = vt[i].iv;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d", i), outs(), vt[i].exp);
    end
    bus.key_valid = 1'b0;

    // reset pulsed in the middle of an evaluation
    press(2); press(10); press(3); press(14);
    check("eval_entered", outs(), pack(2, 3, 0, 1, 3, 1, 0));
    bus.res = 16'd77;
    bus.isValid = 1'b1;
    rst = 1'b1;
    #1;
    check("rst_in_eval_immediate", outs(), pack(0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_in_eval_held", outs(), pack(0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("post_abort%0d", i), outs(), pack(0, 0, 0, 0, 0, 0, 0));
    end

    // reset must win over a simultaneous key
    bus.key_valid = 1'b1;
    bus.key_code  = 4'd5;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.key_valid = 1'b0;
    check("rst_dominates_key", outs(), pack(0, 0, 0, 0, 0, 0, 0));

    // randomized run against the behavioural model
    model_reset();
    prev_go = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      int sel, kc;
      bit kv, iv;
      int r;
      kv  = ($urandom_range(0, 99) < 60);
      sel = $urandom_range(0, 99);
      if (sel < 55)      kc = $urandom_range(0, 9);
      else if (sel < 75) kc = $urandom_range(10, 13);
      else if (sel < 93) kc = 14;
      else               kc = 15;
      r  = $urandom_range(0, 65535);
      iv = ($urandom_range(0, 99) < 80);
      bus.key_valid = kv;
      bus.key_code  = 4'(kc);
      bus.res       = 16'(r);
      bus.isValid   = iv;
      @(posedge clk);
      model_step(kv, kc, r, iv);
      @(negedge clk);
      check($sformatf("rand%0d", i), outs(),
            pack(m_a, m_b, m_op, m_go, m_disp, m_busy, m_err));
      check($sformatf("go_twice%0d", i), 53'(prev_go & bus.calc_go), 53'd0);
      prev_go = bus.calc_go;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/calc_key_sequencer.md
CALC_KEY_SEQUENCER -- requirements
Module: calc_key_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port key_valid, input, 1 bit: one-cycle strobe qualifying key_code.
REQ-004 SHALL have port key_code, input, 4 bits: 0-9 digit, 10-13 operator (op = code-10), 14 equals, 15 clear.
REQ-005 SHALL have port res, input, 16 bits: ALU result.
REQ-006 SHALL have port isValid, input, 1 bit: ALU result valid.
REQ-007 SHALL have port num1, output, 16 bits: ALU first operand, registered.
REQ-008 SHALL have port num2, output, 16 bits: ALU second operand, registered.
REQ-009 SHALL have port op, output, 2 bits: ALU operation (00 sum, 01 sub, 10 mul, 11 div), registered.
REQ-010 SHALL have port calc_go, output, 1 bit: one-cycle strobe, high while the ALU result is sampled.
REQ-011 SHALL have port display, output, 16 bits: value to show, registered.
REQ-012 SHALL have port busy, output, 1 bit: high in EVAL.
REQ-013 SHALL have port error, output, 1 bit: high in ERROR.

Function
REQ-014 SHALL implement states ENTRY_A, ENTRY_B, EVAL, RESULT, ERROR; each key is acted on in the cycle key_valid is high.
REQ-015 Digit d SHALL update the active operand to operand*10+d, and display to the new value, only if the result is <=65535; otherwise the digit is ignored and the operand is held.
REQ-016 ENTRY_A: digit -> num1; operator -> latch op, clear num2, go to ENTRY_B; equals ignored.
REQ-017 ENTRY_B: digit -> num2; operator -> replace op only if no digit has yet been accepted into num2, else ignored; equals -> go to EVAL.
REQ-018 EVAL SHALL last exactly one cycle with calc_go=1 and busy=1; num1/num2/op SHALL be stable throughout; non-clear keys SHALL be ignored.
REQ-019 At the end of EVAL: isValid=1 -> num1=res, display=res, go to RESULT; isValid=0 -> display=0, go to ERROR.
REQ-020 RESULT: digit d -> num1=d, display=d, go to ENTRY_A; operator -> latch op, num2=0, go to ENTRY_B (chaining); equals -> EVAL again with current num1, num2, op.
REQ-021 ERROR: all keys except clear SHALL be ignored.
REQ-022 Clear (code 15) SHALL be accepted in every state, including EVAL, and SHALL restore reset values on the next edge.
REQ-023 calc_go SHALL never be high in two consecutive cycles.

Reset
REQ-024 While rst=1, outputs SHALL immediately take: state ENTRY_A, num1=0, num2=0, op=00, display=0, calc_go=0, busy=0, error=0; the digit-entered flag cleared.
REQ-025 rst SHALL dominate key_valid in the same cycle; a reset asserted during EVAL SHALL abort the evaluation with no result captured.

Structure
REQ-026 Shared package calc_pkg SHALL hold the op encodings, key-code constants (DIGIT_MAX=9, KEY_EQ=14, KEY_CLR=15, op base 10), the state encoding and the 65535 operand limit.
REQ-027 One sub-module, calc_digit_accum, SHALL compute operand*10+d and the overflow flag combinationally; the sequencer SHALL instantiate it once, muxed to the active operand.

Verification
REQ-028 Reset; keys 5, 10, 1, 14 -> one calc_go cycle with num1=5, num2=1, op=00; with res=6, isValid=1 -> display=6, state RESULT.
REQ-029 Keys 6, 5, 5, 3, 5 -> num1=65535; then key 0 -> num1 and display stay 65535.
REQ-030 Keys 8, 13, 0, 14 with isValid=0 -> error=1, display=0; key 1 ignored; key 15 -> error=0, num1=0.
REQ-031 From RESULT 6: keys 11, 2, 14 -> num1=6, num2=2, op=01, with res=4 display=4; key 14 again -> num1=4, num2=2, calc_go again.
REQ-032 Keys 3, 10, 12, 4, 14 -> op=10 at calc_go; keys 3, 10, 4, 12 -> op stays 00.
REQ-033 rst pulsed during the EVAL cycle -> all outputs zero immediately, no result captured, no further calc_go.
